// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_arbiter
// Purpose  : Shares the register file's single write port between two
//            writeback sources (A = ALU path, B = load/multiply path).
//            Round-robin arbitration on ties, zero-latency valid/grant
//            handshake, stall input, register-0 write suppression and a
//            saturating commit counter. The write port is driven from a
//            registered output stage feeding the 5-to-32 write decoder.
// Ports    : clk, rst_n (sync, active-low), stall
//            a_req/a_addr/a_data -> a_gnt   requester A
//            b_req/b_addr/b_data -> b_gnt   requester B
//            wr_en/wr_addr/wr_data          registered write port
//            commit_cnt                     saturating count of writes
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             a_req,
    input  logic [0:4]       a_addr,
    input  logic [0:31]      a_data,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic [0:4]       b_addr,
    input  logic [0:31]      b_data,
    output logic             b_gnt,
    output logic             wr_en,
    output logic [0:4]       wr_addr,
    output logic [0:31]      wr_data,
    output logic [0:CNT_W-1] commit_cnt
);

    // Encoding of the "last winner" bit.
    localparam logic c_LAST_A = 1'b0;
    localparam logic c_LAST_B = 1'b1;

    localparam logic [0:CNT_W-1] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_last;
    logic             r_wr_en;
    logic [0:4]       r_wr_addr;
    logic [0:31]      r_wr_data;
    logic [0:CNT_W-1] r_commit_cnt;

    logic             w_arb_ok;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic [0:4]       w_sel_addr;
    logic [0:31]      w_sel_data;
    logic             w_wr_load;
    logic             w_cnt_sat;

    // Reset is folded into the grant so a requester never sees a grant
    // on an edge that discards its write.
    assign w_arb_ok = rst_n & ~stall;

    // On a tie the requester that did not win last time is granted.
    assign w_a_gnt = w_arb_ok & a_req & (~b_req | (r_last == c_LAST_B));
    assign w_b_gnt = w_arb_ok & b_req & (~a_req | (r_last == c_LAST_A));

    assign w_sel_addr = w_a_gnt ? a_addr : b_addr;
    assign w_sel_data = w_a_gnt ? a_data : b_data;

    // A grant targeting $zero completes the handshake but performs no write.
    assign w_wr_load = (w_a_gnt | w_b_gnt) & (|w_sel_addr);
    assign w_cnt_sat = &r_commit_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last       <= c_LAST_B;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_commit_cnt <= '0;
        end else begin
            if (w_a_gnt) begin
                r_last <= c_LAST_A;
            end else if (w_b_gnt) begin
                r_last <= c_LAST_B;
            end

            r_wr_en <= w_wr_load;

            // Address/data hold unless a real write is loaded.
            if (w_wr_load) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end

            if (w_wr_load && !w_cnt_sat) begin
                r_commit_cnt <= r_commit_cnt + c_CNT_ONE;
            end
        end
    end

    assign a_gnt      = w_a_gnt;
    assign b_gnt      = w_b_gnt;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign commit_cnt = r_commit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_arbiter
// Purpose  : Self-checking bench for regfile_wr_arbiter. Two instances
//            (CNT_W=16 and CNT_W=4) share one stimulus stream; a
//            behavioural model predicts grants and write-port contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        a_req;
    logic [0:4]  a_addr;
    logic [0:31] a_data;
    logic        b_req;
    logic [0:4]  b_addr;
    logic [0:31] b_data;

    logic        a_gnt,  b_gnt,  wr_en;
    logic [0:4]  wr_addr;
    logic [0:31] wr_data;
    logic [0:15] commit_cnt;

    logic        a_gnt4, b_gnt4, wr_en4;
    logic [0:4]  wr_addr4;
    logic [0:31] wr_data4;
    logic [0:3]  commit_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_cnt(commit_cnt)
    );

    regfile_wr_arbiter #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt4),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .commit_cnt(commit_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte         m_last_winner;   // "A" or "B"
    bit          m_wr_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_known;         // addr/data value is defined by the rules
    int          m_cnt16;
    int          m_cnt4;
    bit          m_started = 0;

    function automatic void model_grants(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (rst_n === 1'b1 && stall === 1'b0) begin
            if (a_req && b_req) begin
                if (m_last_winner == "A") gb = 1; else ga = 1;
            end else if (a_req) begin
                ga = 1;
            end else if (b_req) begin
                gb = 1;
            end
        end
    endfunction

    bit          mg_a, mg_b;
    logic [4:0]  mg_addr;
    always @(posedge clk) begin
        model_grants(mg_a, mg_b);
        if (rst_n !== 1'b1) begin
            m_last_winner = "B";
            m_wr_en = 0; m_addr = 0; m_data = 0; m_known = 1;
            m_cnt16 = 0; m_cnt4 = 0;
        end else if (mg_a || mg_b) begin
            mg_addr       = mg_a ? a_addr : b_addr;
            m_last_winner = mg_a ? "A" : "B";
            if (mg_addr != 0) begin
                m_wr_en = 1;
                m_addr  = mg_addr;
                m_data  = mg_a ? a_data : b_data;
                m_known = 1;
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end else begin
                m_wr_en = 0;
                m_known = 0;
            end
        end else begin
            m_wr_en = 0;
        end
        m_started = 1;
    end

    // ---------------- compare process ----------------
    bit cg_a, cg_b;
    always @(negedge clk) begin
        if (m_started) begin
            model_grants(cg_a, cg_b);
            chk("a_gnt", a_gnt, cg_a);
            chk("b_gnt", b_gnt, cg_b);
            chk("gnt_exclusive", a_gnt & b_gnt, 0);
            chk("a_gnt4", a_gnt4, cg_a);
            chk("b_gnt4", b_gnt4, cg_b);
            chk("wr_en", wr_en, m_wr_en);
            chk("wr_en4", wr_en4, m_wr_en);
            chk("commit_cnt16", commit_cnt, m_cnt16);
            chk("commit_cnt4", commit_cnt4, m_cnt4);
            if (m_known) begin
                chk("wr_addr", wr_addr, m_addr);
                chk("wr_data", wr_data, m_data);
                chk("wr_addr4", wr_addr4, m_addr);
                chk("wr_data4", wr_data4, m_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ga, gb;
        rst_n = 0; stall = 0;
        a_req = 0; a_addr = '0; a_data = '0;
        b_req = 0; b_addr = '0; b_data = '0;
        step(); step();
        rst_n = 1;

        // A alone after reset
        a_req = 1; a_addr = 5'd7; a_data = 32'hDEADBEEF;
        #1;
        chk("t1_a_gnt", a_gnt, 1);
        chk("t1_b_gnt", b_gnt, 0);
        step();
        a_req = 0;
        chk("t1_wr_en", wr_en, 1);
        chk("t1_wr_addr", wr_addr, 7);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        chk("t1_cnt", commit_cnt, 1);

        // Tie after reset: A, B, A, B
        rst_n = 0; step(); rst_n = 1;
        a_req = 1; a_addr = 5'd3; a_data = 32'h33;
        b_req = 1; b_addr = 5'd9; b_data = 32'h99;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_a_gnt", a_gnt, (i % 2 == 0));
            chk("t2_b_gnt", b_gnt, (i % 2 == 1));
            step();
            chk("t2_wr_en", wr_en, 1);
            chk("t2_wr_addr", wr_addr, (i % 2 == 0) ? 3 : 9);
        end
        a_req = 0; b_req = 0;
        chk("t2_cnt", commit_cnt, 4);

        // Zero register from B
        b_req = 1; b_addr = 5'd0; b_data = 32'h1;
        #1;
        chk("t3_b_gnt", b_gnt, 1);
        step();
        b_req = 0;
        chk("t3_wr_en", wr_en, 0);
        chk("t3_cnt", commit_cnt, 4);

        // Stall with both requesting; last winner is B
        a_req = 1; a_addr = 5'd3; b_req = 1; b_addr = 5'd9; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_a_gnt", a_gnt, 0);
            chk("t4_b_gnt", b_gnt, 0);
            step();
            chk("t4_wr_en", wr_en, 0);
        end
        stall = 0;
        #1;
        chk("t4_post_a_gnt", a_gnt, 1);
        chk("t4_post_b_gnt", b_gnt, 0);
        step();

        // Reset mid-operation with last winner A
        rst_n = 0;
        #1;
        chk("t5_rst_a_gnt", a_gnt, 0);
        chk("t5_rst_b_gnt", b_gnt, 0);
        step();
        chk("t5_wr_en", wr_en, 0);
        chk("t5_wr_addr", wr_addr, 0);
        chk("t5_wr_data", wr_data, 0);
        chk("t5_cnt", commit_cnt, 0);
        rst_n = 1;
        #1;
        chk("t5_first_a_gnt", a_gnt, 1);
        chk("t5_first_b_gnt", b_gnt, 0);
        step();
        a_req = 0; b_req = 0;

        // Saturation of the 4-bit counter
        rst_n = 0; step(); rst_n = 1;
        a_req = 1; a_addr = 5'd5;
        for (int i = 1; i <= 17; i++) begin
            a_data = i;
            step();
            if (i == 14) chk("t6_cnt4_14", commit_cnt4, 4'hE);
            if (i == 15 || i == 17) chk("t6_cnt4_sat", commit_cnt4, 4'hF);
        end
        chk("t6_cnt16", commit_cnt, 17);
        a_req = 0;

        // Randomised phase, handshake rules respected
        for (int n = 0; n < 4000; n++) begin
            model_grants(ga, gb);
            step();
            if (!a_req || ga) begin
                a_req  = ($urandom_range(0, 3) != 0);
                a_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                a_data = $urandom;
            end
            if (!b_req || gb) begin
                b_req  = ($urandom_range(0, 3) != 0);
                b_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                b_data = $urandom;
            end
            stall = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
        end
        a_req = 0; b_req = 0; stall = 0; rst_n = 1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
